// File: rtl/wb_retire_tracer.sv
// Retirement tracer: captures every register-file write from writeback into a small
// first-word-fall-through FIFO, plus free-running cycle/retire/drop counters.
module wb_retire_tracer #(
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 32,
    parameter bit FILTER_X0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_rd,
    input  logic [31:0]              wb_data,
    input  logic [31:0]              wb_pc,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [4:0]               trace_rd,
    output logic [31:0]              trace_data,
    output logic [31:0]              trace_pc,
    output logic [CNT_W-1:0]         trace_cycle,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         retire_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [4:0]       mem_rd    [DEPTH];
    logic [31:0]      mem_data  [DEPTH];
    logic [31:0]      mem_pc    [DEPTH];
    logic [CNT_W-1:0] mem_cycle [DEPTH];

    logic push_req;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        push_req = wb_valid && !(FILTER_X0 && (wb_rd == 5'd0));
        full     = (level == LVL_W'(DEPTH));
        pop      = trace_valid && trace_ready;
        // A full FIFO can still accept a write when the head leaves in the same cycle.
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    assign trace_valid = (level != '0);
    assign trace_rd    = trace_valid ? mem_rd[rd_ptr]    : '0;
    assign trace_data  = trace_valid ? mem_data[rd_ptr]  : '0;
    assign trace_pc    = trace_valid ? mem_pc[rd_ptr]    : '0;
    assign trace_cycle = trace_valid ? mem_cycle[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]    <= wb_rd;
            mem_data[wr_ptr]  <= wb_data;
            mem_pc[wr_ptr]    <= wb_pc;
            mem_cycle[wr_ptr] <= cycle_count;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count  <= '0;
            retire_count <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            cycle_count <= cycle_count + CNT_W'(1);
            if (wb_valid) retire_count <= retire_count + CNT_W'(1);
            if (drop) begin
                drop_count <= drop_count + CNT_W'(1);
                overflow   <= 1'b1;
            end
        end
    end

endmodule
